// File: rtl/spi_target_mem_responder_pkg.sv
// Shared opcodes, FSM state type and status-register layout for the SPI
// memory-emulating target.
package spi_target_pkg;

  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_RDSR  = 8'h05;
  localparam logic [7:0] OP_WREN  = 8'h06;
  localparam logic [7:0] OP_WRDI  = 8'h04;

  localparam int unsigned STATUS_WIP_BIT = 0;
  localparam int unsigned STATUS_WEL_BIT = 1;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    RD_DATA,
    WR_DATA,
    STATUS,
    IGNORE
  } state_e;

  function automatic logic [7:0] status_byte(input logic wel);
    logic [7:0] s;
    s = '0;
    s[STATUS_WEL_BIT] = wel;
    s[STATUS_WIP_BIT] = 1'b0;
    return s;
  endfunction

endpackage

// File: rtl/spi_target_mem_responder_if.sv
// SPI pad bundle between the SoC master and the memory-emulating target.
interface spi_target_mem_responder_if;
  logic sck;
  logic csn;
  logic mosi;
  logic miso;
  logic miso_oe;

  modport master (output sck, output csn, output mosi, input miso, input miso_oe);
  modport slave  (input sck, input csn, input mosi, output miso, output miso_oe);
endinterface

// File: rtl/spi_target_mem_responder_pin_sync.sv
// Synchroniser chain plus registered edge detector for one asynchronous SPI pin.
// Pin-to-pulse latency is SYNC_STAGES+1 clocks; level is aligned with the pulses.
module spi_pin_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync  <= {SYNC_STAGES{RST_VAL}};
      level <= RST_VAL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], pin};
      level <= sync[SYNC_STAGES-1];
      rise  <= sync[SYNC_STAGES-1] & ~level;
      fall  <= ~sync[SYNC_STAGES-1] & level;
    end
  end

endmodule

// File: rtl/spi_target_mem_responder.sv
// Mode-0 SPI target emulating a small serial memory (READ/WRITE/RDSR/WREN/WRDI)
// with an internal synchronous-read byte array; SPI pins are oversampled in clk_i.
module spi_target_mem_responder
  import spi_target_pkg::*;
#(
  parameter int unsigned MEM_BYTES   = 256,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  spi_target_mem_responder_if.slave   spi,
  output logic                        cmd_err_o,
  output logic                        wel_o
);

  localparam int unsigned AW = $clog2(MEM_BYTES);

  logic sck_level, sck_rise, sck_fall;
  logic csn_level, cs_fall, cs_rise;
  logic mosi_level, mosi_rise, mosi_fall;

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk(clk_i), .rst(rst_i), .pin(spi.sck),
    .level(sck_level), .rise(sck_rise), .fall(sck_fall)
  );

  // csn idles high, so its synchroniser resets high to avoid a false select.
  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_csn (
    .clk(clk_i), .rst(rst_i), .pin(spi.csn),
    .level(csn_level), .rise(cs_rise), .fall(cs_fall)
  );

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk_i), .rst(rst_i), .pin(spi.mosi),
    .level(mosi_level), .rise(mosi_rise), .fall(mosi_fall)
  );

  logic unused;
  assign unused = &{1'b0, sck_level, csn_level, mosi_rise, mosi_fall};

  state_e          state, state_next;
  logic [2:0]      bit_cnt;
  logic [4:0]      addr_cnt;
  logic [6:0]      shift_in;
  logic [7:0]      shift_out;
  logic [AW-1:0]   addr;
  logic            is_write;
  logic            wel;
  logic            cmd_err;
  logic            load_pending;
  logic            miso;
  logic [7:0]      rd_data;
  logic [7:0]      opcode;
  logic [7:0]      load_val;
  logic            take_bit, byte_done;
  logic            set_wel, clr_wel, cmd_bad, go_write;
  logic            mem_we;
  logic [7:0]      mem [MEM_BYTES];

  assign opcode   = {shift_in, mosi_level};
  assign load_val = (state == STATUS) ? status_byte(wel) : rd_data;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    take_bit   = 1'b0;
    byte_done  = 1'b0;
    set_wel    = 1'b0;
    clr_wel    = 1'b0;
    cmd_bad    = 1'b0;
    go_write   = 1'b0;
    // cs_rise dominates a coincident sck_rise: the bit is not taken.
    if (cs_rise) begin
      state_next = IDLE;
    end else begin
      take_bit  = sck_rise && (state inside {CMD, ADDR, RD_DATA, WR_DATA, STATUS});
      byte_done = take_bit && (bit_cnt == 3'd7);
      unique case (state)
        IDLE: if (cs_fall) state_next = CMD;
        CMD: begin
          if (byte_done) begin
            case (opcode)
              OP_READ:  state_next = ADDR;
              OP_WRITE: begin state_next = ADDR; go_write = 1'b1; end
              OP_RDSR:  state_next = STATUS;
              OP_WREN:  begin state_next = IGNORE; set_wel = 1'b1; end
              OP_WRDI:  begin state_next = IGNORE; clr_wel = 1'b1; end
              default:  begin state_next = IGNORE; cmd_bad = 1'b1; end
            endcase
          end
        end
        ADDR: if (take_bit && addr_cnt == 5'd23) state_next = is_write ? WR_DATA : RD_DATA;
        default: ;
      endcase
    end
  end

  assign mem_we = byte_done && (state == WR_DATA) && wel && !rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bit_cnt      <= '0;
      addr_cnt     <= '0;
      shift_in     <= '0;
      shift_out    <= '0;
      addr         <= '0;
      is_write     <= 1'b0;
      wel          <= 1'b0;
      cmd_err      <= 1'b0;
      load_pending <= 1'b0;
      miso         <= 1'b0;
    end else begin
      cmd_err <= cmd_bad;

      if (cs_fall || state_next == IDLE) bit_cnt <= '0;
      else if (take_bit)                 bit_cnt <= bit_cnt + 1'b1;

      if (take_bit) shift_in <= {shift_in[5:0], mosi_level};

      if (state == CMD)                         addr_cnt <= '0;
      else if (take_bit && state == ADDR)       addr_cnt <= addr_cnt + 1'b1;

      if (take_bit && state == ADDR)
        addr <= {addr[AW-2:0], mosi_level};
      else if (byte_done && (state inside {RD_DATA, WR_DATA}))
        addr <= addr + 1'b1;

      if (go_write)           is_write <= 1'b1;
      else if (state == IDLE) is_write <= 1'b0;

      if (cs_rise && is_write) wel <= 1'b0;
      else if (set_wel)        wel <= 1'b1;
      else if (clr_wel)        wel <= 1'b0;

      // Each byte boundary arms a reload; the next sck_fall presents its MSB.
      if (state_next inside {RD_DATA, STATUS}) begin
        if (byte_done) begin
          load_pending <= 1'b1;
        end else if (sck_fall) begin
          if (load_pending) begin
            miso         <= load_val[7];
            shift_out    <= {load_val[6:0], 1'b0};
            load_pending <= 1'b0;
          end else begin
            miso      <= shift_out[7];
            shift_out <= {shift_out[6:0], 1'b0};
          end
        end
      end else begin
        miso         <= 1'b0;
        load_pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) mem[addr] <= opcode;
    rd_data <= mem[addr];
  end

  assign spi.miso    = miso;
  assign spi.miso_oe = (state == RD_DATA) || (state == STATUS);
  assign cmd_err_o   = cmd_err;
  assign wel_o       = wel;

endmodule
